// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the pipeline control (master) and the PC stage (slave).
interface pc_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        misalign;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           exc_req, eret, epc,
    input  pc, pc_plus4, valid, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           exc_req, eret, epc,
    output pc, pc_plus4, valid, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// MIPS program-counter stage: sequential fetch, delayed branch/jump redirect, exception vectoring.
// Optional eret/epc return path is built only when PC_ERET_EN is defined.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input logic      clk,
  input logic      rst_n,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        valid_q;
  logic        misalign_q;
  logic [31:0] pc_inc;
  logic [31:0] redirect;

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = bus.jump ? bus.jump_target : bus.branch_target;

`ifndef PC_ERET_EN
  logic unused_eret;
  assign unused_eret = ^{bus.eret, bus.epc};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_q       <= RESET_VECTOR;
      target_q   <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (state == IDLE) begin
        state <= RUN;
      end else if (bus.exc_req) begin
        pc_q       <= EXC_VECTOR;
        misalign_q <= (EXC_VECTOR[1:0] != 2'b00);
        target_q   <= '0;
        state      <= RUN;
      end else if (!bus.stall) begin
`ifdef PC_ERET_EN
        if (bus.eret) begin
          pc_q       <= bus.epc;
          misalign_q <= (bus.epc[1:0] != 2'b00);
          target_q   <= '0;
          state      <= RUN;
        end else
`endif
        // Redirect requests arriving in PEND (delay-slot branch) are dropped.
        if (state == PEND) begin
          pc_q       <= target_q;
          misalign_q <= (target_q[1:0] != 2'b00);
          target_q   <= '0;
          state      <= RUN;
        end else begin
          pc_q       <= pc_inc;
          misalign_q <= (pc_inc[1:0] != 2'b00);
          if (bus.jump || bus.branch_taken) begin
            target_q <= redirect;
            state    <= PEND;
          end
        end
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_inc;
  assign bus.valid    = valid_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then random traffic against a queue-based model.
module tb_pc_unit;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
`ifdef PC_ERET_EN
  localparam bit ERET_EN = 1'b1;
`else
  localparam bit ERET_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        misalign;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if bus ();

  pc_unit #(
    .RESET_VECTOR(RESET_VECTOR),
    .EXC_VECTOR  (EXC_VECTOR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  exp_t        sb[$];

  // Stimulus for the next edge.
  bit          s_rst, s_stall, s_b, s_j, s_exc, s_eret;
  logic [31:0] s_bt, s_jt, s_epc;

  // Reference model: fetch address, whether fetching has begun, and outstanding redirects.
  logic [31:0] m_pc    = RESET_VECTOR;
  logic        m_valid = 1'b0;
  logic [31:0] pend_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    s_rst = 0; s_stall = 0; s_b = 0; s_j = 0; s_exc = 0; s_eret = 0;
    s_bt = '0; s_jt = '0; s_epc = '0;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    rst_n             = ~s_rst;
    bus.stall         = s_stall;
    bus.branch_taken  = s_b;
    bus.branch_target = s_bt;
    bus.jump          = s_j;
    bus.jump_target   = s_jt;
    bus.exc_req       = s_exc;
    bus.eret          = s_eret;
    bus.epc           = s_epc;
    if (s_rst) begin
      m_pc    = RESET_VECTOR;
      m_valid = 1'b0;
      pend_q.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (s_exc) begin
      m_pc = EXC_VECTOR;
      pend_q.delete();
    end else if (!s_stall) begin
      if (ERET_EN && s_eret) begin
        m_pc = s_epc;
        pend_q.delete();
      end else if (pend_q.size() != 0) begin
        m_pc = pend_q.pop_front();
      end else begin
        if (s_j) pend_q.push_back(s_jt);
        else if (s_b) pend_q.push_back(s_bt);
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc       = m_pc;
    e.valid    = m_valid;
    e.misalign = (m_pc[1:0] != 2'b00);
    sb.push_back(e);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("pc",       bus.pc,               mon_e.pc);
      chk("pc_plus4", bus.pc_plus4,         mon_e.pc + 32'd4);
      chk("valid",    {31'd0, bus.valid},    {31'd0, mon_e.valid});
      chk("misalign", {31'd0, bus.misalign}, {31'd0, mon_e.misalign});
    end
  end

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    clr();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0;
    bus.jump_target = '0; bus.exc_req = 0; bus.eret = 0; bus.epc = '0;

    // Reset with exc_req asserted: reset must win.
    for (int i = 0; i < 3; i++) begin clr(); s_rst = 1; s_exc = (i == 1); tick(); end
    clr(); tick(); tick(); tick();

    // Reach 0x100, then branch to 0x200.
    clr(); s_j = 1; s_jt = 32'h100; tick();
    clr(); tick();
    clr(); s_b = 1; s_bt = 32'h200; tick();
    clr(); tick(); tick();

    // Branch, then stall twice in PEND, with jumps in PEND dropped.
    clr(); s_j = 1; s_jt = 32'h100; tick();
    clr(); tick();
    clr(); s_b = 1; s_bt = 32'h200; tick();
    clr(); s_stall = 1; tick();
    clr(); s_stall = 1; s_j = 1; s_jt = 32'h500; tick();
    clr(); s_j = 1; s_jt = 32'h500; tick();
    clr(); tick();

    // Jump beats branch, exception in PEND discards the jump target.
    clr(); s_j = 1; s_jt = 32'h300; s_b = 1; s_bt = 32'h200; tick();
    clr(); s_exc = 1; tick();
    clr(); tick(); tick();

    // eret
    clr(); s_eret = 1; s_epc = 32'h0040_0010; tick();
    clr(); tick();

    // Misaligned target, then exception clears misalign.
    clr(); s_j = 1; s_jt = 32'h1002; tick();
    clr(); tick(); tick();
    clr(); s_exc = 1; tick();

    // Wrap at the top of the address space.
    clr(); s_j = 1; s_jt = 32'hFFFF_FFF8; tick();
    clr(); tick(); tick(); tick();

    // Exception while stalled, then eret while stalled (ignored).
    clr(); s_stall = 1; s_exc = 1; tick();
    clr(); s_stall = 1; s_eret = 1; s_epc = 32'h1234_5678; tick();
    clr(); tick();

    for (int unsigned i = 0; i < 800; i++) begin
      clr();
      s_rst   = ($urandom_range(0, 99) < 2);
      s_stall = ($urandom_range(0, 99) < 20);
      s_b     = ($urandom_range(0, 99) < 20);
      s_j     = ($urandom_range(0, 99) < 15);
      s_exc   = ($urandom_range(0, 99) < 4);
      s_eret  = ($urandom_range(0, 99) < 5);
      s_bt    = rand_target();
      s_jt    = rand_target();
      s_epc   = rand_target();
      tick();
    end

    @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
